// File: rtl/mem_control_pkg.sv
// Shared types for the CPU-to-bus memory access controller.
package mem_control_pkg;

  // FSM state encoding; value 7 is unused and recovers to IDLE.
  typedef enum logic [2:0] {
    INIT          = 3'd0,
    IDLE          = 3'd1,
    Read_Request  = 3'd2,
    Write_Request = 3'd3,
    Read          = 3'd4,
    Write         = 3'd5,
    Wait          = 3'd6
  } state_t;

  // Kind of request latched at acceptance; steers where read data lands.
  typedef enum logic [1:0] {
    WRITE     = 2'd0,
    DATA_READ = 2'd1,
    FETCH     = 2'd2
  } req_type_t;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

endpackage

// File: rtl/mem_control.sv
// Memory access controller: serialises CPU data reads, data writes and
// instruction fetches onto one shared bus, stalling while bus_full is high.
module mem_control
  import mem_control_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [DATA_W-1:0] data_in_CPU,
  input  logic [DATA_W-1:0] data_in_BUS,
  input  logic              data_en,
  input  logic              instr_en,
  input  logic              bus_full,
  input  logic              memWrite,
  input  logic              memRead,
  output logic [2:0]        state,
  output logic [ADDR_W-1:0] address_out,
  output logic [DATA_W-1:0] data_out_CPU,
  output logic [DATA_W-1:0] data_out_BUS,
  output logic [DATA_W-1:0] data_out_INSTR
);

  state_t            r_state;
  state_t            w_state_next;
  req_type_t         r_type;
  logic [ADDR_W-1:0] r_address_out;
  logic [DATA_W-1:0] r_data_out_cpu;
  logic [DATA_W-1:0] r_data_out_bus;
  logic [DATA_W-1:0] r_data_out_instr;

  // IDLE arbitration: a write wins over a read (even if memRead is also set),
  // a data read wins over a fetch. A losing fetch is not queued.
  logic w_idle;
  logic w_take_write;
  logic w_take_read;
  logic w_take_fetch;
  logic w_capture;

  assign w_idle       = (r_state == IDLE);
  assign w_take_write = w_idle && data_en && memWrite;
  assign w_take_read  = w_idle && data_en && memRead && !memWrite;
  assign w_take_fetch = w_idle && instr_en && !w_take_write && !w_take_read;
  assign w_capture    = (r_state == Read) && !bus_full;

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; bus phases hold while the bus reports full.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      INIT:          w_state_next = IDLE;
      IDLE: begin
        if (w_take_write) begin
          w_state_next = Write_Request;
        end else if (w_take_read || w_take_fetch) begin
          w_state_next = Read_Request;
        end
      end
      Read_Request:  if (!bus_full) w_state_next = Read;
      Read:          if (!bus_full) w_state_next = Wait;
      Write_Request: if (!bus_full) w_state_next = Write;
      Write:         if (!bus_full) w_state_next = Wait;
      Wait:          w_state_next = IDLE;
      default:       w_state_next = IDLE;
    endcase
  end

  // Registered outputs: latch request fields on acceptance, capture read data
  // in the Read phase so it is visible from the first Wait cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_type           <= WRITE;
      r_address_out    <= '0;
      r_data_out_cpu   <= '0;
      r_data_out_bus   <= '0;
      r_data_out_instr <= '0;
    end else begin
      if (w_take_write) begin
        r_address_out  <= address_in;
        r_data_out_bus <= data_in_CPU;
        r_type         <= WRITE;
      end else if (w_take_read) begin
        r_address_out  <= address_in;
        r_type         <= DATA_READ;
      end else if (w_take_fetch) begin
        r_address_out  <= address_in;
        r_type         <= FETCH;
      end
      if (w_capture) begin
        if (r_type == DATA_READ) begin
          r_data_out_cpu <= data_in_BUS;
        end else if (r_type == FETCH) begin
          r_data_out_instr <= data_in_BUS;
        end
      end
    end
  end

  assign state          = r_state;
  assign address_out    = r_address_out;
  assign data_out_CPU   = r_data_out_cpu;
  assign data_out_BUS   = r_data_out_bus;
  assign data_out_INSTR = r_data_out_instr;

endmodule

// File: tb/tb_mem_control.sv
// Directed bench for mem_control: reset, read, write, stalled fetch,
// arbitration priority and mid-transfer reset.
module tb_mem_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address_in;
  logic [31:0] data_in_CPU;
  logic [31:0] data_in_BUS;
  logic        data_en;
  logic        instr_en;
  logic        bus_full;
  logic        memWrite;
  logic        memRead;
  logic [2:0]  state;
  logic [31:0] address_out;
  logic [31:0] data_out_CPU;
  logic [31:0] data_out_BUS;
  logic [31:0] data_out_INSTR;

  int total = 0;
  int bad   = 0;

  mem_control dut (
    .clk            (clk),
    .rst            (rst),
    .address_in     (address_in),
    .data_in_CPU    (data_in_CPU),
    .data_in_BUS    (data_in_BUS),
    .data_en        (data_en),
    .instr_en       (instr_en),
    .bus_full       (bus_full),
    .memWrite       (memWrite),
    .memRead        (memRead),
    .state          (state),
    .address_out    (address_out),
    .data_out_CPU   (data_out_CPU),
    .data_out_BUS   (data_out_BUS),
    .data_out_INSTR (data_out_INSTR)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle on the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_req();
    data_en  = 1'b0;
    instr_en = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (address_out !== 32'h0 || data_out_BUS !== 32'h0) begin bad++; $display("FAIL reset_bus got addr=%h bus=%h exp=0", address_out, data_out_BUS); end
    total++; if (data_out_CPU !== 32'h0 || data_out_INSTR !== 32'h0) begin bad++; $display("FAIL reset_cpu got cpu=%h instr=%h exp=0", data_out_CPU, data_out_INSTR); end
    rst = 1'b0;
    tick();
    total++; if (state !== 3'd1) begin bad++; $display("FAIL init_to_idle got=%0d exp=1", state); end
    // data_en without memRead/memWrite is ignored
    data_en = 1'b1;
    tick();
    total++; if (state !== 3'd1) begin bad++; $display("FAIL ignore_bare_data_en got=%0d exp=1", state); end
    clear_req();
    $display("reset: state=%0d", state);
  endtask

  task automatic test_read();
    address_in = 32'h0000_0040; data_en = 1'b1; memRead = 1'b1; data_in_BUS = 32'hDEAD_BEEF;
    tick();
    total++; if (state !== 3'd2) begin bad++; $display("FAIL read_req got=%0d exp=2", state); end
    total++; if (address_out !== 32'h40) begin bad++; $display("FAIL read_addr got=%h exp=00000040", address_out); end
    clear_req(); address_in = 32'hFFFF_0000;
    tick();
    total++; if (state !== 3'd4) begin bad++; $display("FAIL read_phase got=%0d exp=4", state); end
    total++; if (data_out_CPU !== 32'h0) begin bad++; $display("FAIL read_early got=%h exp=0", data_out_CPU); end
    tick();
    total++; if (state !== 3'd6) begin bad++; $display("FAIL read_wait got=%0d exp=6", state); end
    total++; if (data_out_CPU !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_data got=%h exp=deadbeef", data_out_CPU); end
    total++; if (data_out_INSTR !== 32'h0) begin bad++; $display("FAIL read_instr_hold got=%h exp=0", data_out_INSTR); end
    total++; if (address_out !== 32'h40) begin bad++; $display("FAIL read_addr_hold got=%h exp=00000040", address_out); end
    tick();
    total++; if (state !== 3'd1) begin bad++; $display("FAIL read_done got=%0d exp=1", state); end
    $display("read: addr=%h data=%h", address_out, data_out_CPU);
  endtask

  task automatic test_write();
    address_in = 32'h100; data_in_CPU = 32'h1234_5678; data_en = 1'b1; memWrite = 1'b1;
    tick();
    total++; if (state !== 3'd3) begin bad++; $display("FAIL write_req got=%0d exp=3", state); end
    total++; if (address_out !== 32'h100) begin bad++; $display("FAIL write_addr got=%h exp=00000100", address_out); end
    total++; if (data_out_BUS !== 32'h1234_5678) begin bad++; $display("FAIL write_data got=%h exp=12345678", data_out_BUS); end
    clear_req(); data_in_CPU = 32'h0BAD_0BAD;
    tick();
    total++; if (state !== 3'd5) begin bad++; $display("FAIL write_phase got=%0d exp=5", state); end
    tick();
    total++; if (state !== 3'd6) begin bad++; $display("FAIL write_wait got=%0d exp=6", state); end
    total++; if (data_out_BUS !== 32'h1234_5678) begin bad++; $display("FAIL write_data_hold got=%h exp=12345678", data_out_BUS); end
    total++; if (data_out_CPU !== 32'hDEAD_BEEF) begin bad++; $display("FAIL write_cpu_hold got=%h exp=deadbeef", data_out_CPU); end
    tick();
    total++; if (state !== 3'd1) begin bad++; $display("FAIL write_done got=%0d exp=1", state); end
    $display("write: addr=%h data=%h", address_out, data_out_BUS);
  endtask

  task automatic test_fetch_stall();
    instr_en = 1'b1; address_in = 32'h0; bus_full = 1'b1; data_in_BUS = 32'h0000_0013;
    tick();
    total++; if (state !== 3'd2) begin bad++; $display("FAIL fetch_req got=%0d exp=2", state); end
    total++; if (address_out !== 32'h0) begin bad++; $display("FAIL fetch_addr got=%h exp=0", address_out); end
    clear_req();
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (state !== 3'd2) begin bad++; $display("FAIL fetch_stall%0d got=%0d exp=2", i, state); end
    end
    bus_full = 1'b0;
    tick();
    total++; if (state !== 3'd4) begin bad++; $display("FAIL fetch_read got=%0d exp=4", state); end
    // stall inside Read: no capture until bus_full drops
    bus_full = 1'b1; data_in_BUS = 32'hFFFF_FFFF;
    tick();
    total++; if (state !== 3'd4 || data_out_INSTR !== 32'h0) begin bad++; $display("FAIL fetch_read_stall got st=%0d instr=%h exp st=4 instr=0", state, data_out_INSTR); end
    bus_full = 1'b0; data_in_BUS = 32'h0000_0013;
    tick();
    total++; if (state !== 3'd6) begin bad++; $display("FAIL fetch_wait got=%0d exp=6", state); end
    total++; if (data_out_INSTR !== 32'h13) begin bad++; $display("FAIL fetch_instr got=%h exp=00000013", data_out_INSTR); end
    total++; if (data_out_CPU !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fetch_cpu_hold got=%h exp=deadbeef", data_out_CPU); end
    tick();
    total++; if (state !== 3'd1) begin bad++; $display("FAIL fetch_done got=%0d exp=1", state); end
    $display("fetch: addr=%h instr=%h", address_out, data_out_INSTR);
  endtask

  task automatic test_priority();
    instr_en = 1'b1; data_en = 1'b1; memRead = 1'b1; memWrite = 1'b1;
    address_in = 32'h200; data_in_CPU = 32'hA5A5_A5A5; data_in_BUS = 32'hCAFE_0000;
    tick();
    total++; if (state !== 3'd3) begin bad++; $display("FAIL prio_write_first got=%0d exp=3", state); end
    total++; if (data_out_BUS !== 32'hA5A5_A5A5) begin bad++; $display("FAIL prio_wdata got=%h exp=a5a5a5a5", data_out_BUS); end
    data_en = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    tick(); tick(); tick();
    total++; if (state !== 3'd1) begin bad++; $display("FAIL prio_idle got=%0d exp=1", state); end
    tick();
    total++; if (state !== 3'd2) begin bad++; $display("FAIL prio_fetch_req got=%0d exp=2", state); end
    instr_en = 1'b0;
    tick(); tick();
    total++; if (state !== 3'd6 || data_out_INSTR !== 32'hCAFE_0000) begin bad++; $display("FAIL prio_fetch got st=%0d instr=%h exp st=6 instr=cafe0000", state, data_out_INSTR); end
    total++; if (data_out_CPU !== 32'hDEAD_BEEF) begin bad++; $display("FAIL prio_cpu_hold got=%h exp=deadbeef", data_out_CPU); end
    tick();
    $display("priority: instr=%h bus=%h", data_out_INSTR, data_out_BUS);
  endtask

  task automatic test_mid_reset();
    address_in = 32'h300; data_en = 1'b1; memRead = 1'b1; data_in_BUS = 32'h5555_5555;
    tick();
    clear_req();
    tick();
    total++; if (state !== 3'd4) begin bad++; $display("FAIL midrst_in_read got=%0d exp=4", state); end
    rst = 1'b1;
    tick();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL midrst_state got=%0d exp=0", state); end
    total++; if (data_out_CPU !== 32'h0 || data_out_INSTR !== 32'h0) begin bad++; $display("FAIL midrst_data got cpu=%h instr=%h exp=0", data_out_CPU, data_out_INSTR); end
    total++; if (address_out !== 32'h0 || data_out_BUS !== 32'h0) begin bad++; $display("FAIL midrst_bus got addr=%h bus=%h exp=0", address_out, data_out_BUS); end
    rst = 1'b0;
    tick();
    total++; if (state !== 3'd1) begin bad++; $display("FAIL midrst_recover got=%0d exp=1", state); end
    $display("mid_reset: state=%0d cpu=%h", state, data_out_CPU);
  endtask

  initial begin
    rst = 1'b1; address_in = '0; data_in_CPU = '0; data_in_BUS = '0;
    bus_full = 1'b0;
    clear_req();
    @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_fetch_stall();
    test_priority();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_control.md
Name: mem_control

Overview:
Memory-access controller between the RV32I CPU core and the external memory bus. It accepts data reads, data writes and instruction fetches from the CPU and serialises them onto one shared bus through a 7-state FSM. It stalls on bus_full and returns read data on separate CPU-data and instruction outputs.

Parameters:
None. Widths are fixed: 32-bit address and data, 3-bit state.

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  reset, synchronous, active-high
address_in  input  32  CPU byte address for the current request
data_in_CPU  input  32  CPU store data
data_in_BUS  input  32  read data returned by the bus
data_en  input  1  CPU requests a data access (qualified by memRead/memWrite)
instr_en  input  1  CPU requests an instruction fetch
bus_full  input  1  bus busy; controller must hold its current phase
memWrite  input  1  data access is a store
memRead  input  1  data access is a load
state  output  3  current FSM state (state_t encoding)
address_out  output  32  address driven to the bus
data_out_CPU  output  32  load data returned to the CPU
data_out_BUS  output  32  store data driven to the bus
data_out_INSTR  output  32  fetched instruction returned to the CPU

Behaviour:
- All outputs are registered.
- On rst=1 at a rising edge:
  - state=INIT.
  - address_out, data_out_CPU, data_out_BUS and data_out_INSTR all = 0.
  - The internal request-type register is cleared.
- rst overrides everything, including a transfer in progress; the partial transfer is abandoned.
- State encoding: INIT=0, IDLE=1, Read_Request=2, Write_Request=3, Read=4, Write=5, Wait=6. Encoding 7 is unused and recovers to IDLE.
- INIT: unconditionally goes to IDLE on the next edge.
- IDLE request arbitration, highest priority first:
  1. data_en & memWrite goes to Write_Request. address_out <= address_in; data_out_BUS <= data_in_CPU; type=WRITE.
  2. data_en & memRead & !memWrite goes to Read_Request. address_out <= address_in; type=DATA_READ.
  3. instr_en goes to Read_Request. address_out <= address_in; type=FETCH.
  4. Otherwise stay in IDLE.
- Arbitration boundary cases:
  - memRead and memWrite both high: treated as a write.
  - data_en with neither memRead nor memWrite: ignored.
  - A fetch that loses arbitration is not queued. The CPU must hold instr_en high, and it is served on the next return to IDLE.
- Read_Request: if bus_full, stay; else go to Read.
- Read: if bus_full, stay. Otherwise capture data_in_BUS and go to Wait:
  - type=DATA_READ: data_out_CPU <= data_in_BUS.
  - type=FETCH: data_out_INSTR <= data_in_BUS.
- Write_Request: if bus_full, stay; else go to Write.
- Write: if bus_full, stay; else go to Wait. The bus takes address_out and data_out_BUS while state==Write and bus_full=0.
- Wait: one completion cycle, then goes to IDLE. Returned data is valid on outputs from the first Wait cycle.
- Hold rules:
  - address_out and data_out_BUS stay latched from acceptance until the next accepted request.
  - data_out_CPU and data_out_INSTR hold their last captured values indefinitely.
  - address_in, data_in_CPU and the enables are sampled only in IDLE; changes mid-transfer have no effect.
- Latency with bus_full=0 throughout: request accepted at edge 0. States run Read_Request/Write_Request (cycle 1), Read/Write (cycle 2), Wait (cycle 3), IDLE (cycle 4). This gives a minimum of 4 cycles per transfer and a back-to-back issue every 4 cycles.
- No address alignment checks or byte enables; the 32-bit address passes through unchanged.

Decomposition:
- Shared package mem_control_pkg holds:
  - typedef enum logic [2:0] state_t, with the values above.
  - A request-type enum {WRITE, DATA_READ, FETCH}.
- Single flat module containing a next-state combinational block and one registered block.
- No sub-module is warranted.

Test Plan:
- Reset: rst=1 for one edge -> state=0, all 32-bit outputs 0. Next edge goes to IDLE(1).
- Data read: address_in=0x0000_0040, data_en=1, memRead=1 in IDLE, data_in_BUS=0xDEAD_BEEF, bus_full=0:
  - states 2,4,6,1; address_out=0x40.
  - data_out_CPU=0xDEADBEEF from the Wait cycle; data_out_INSTR unchanged.
- Write: address_in=0x100, data_in_CPU=0x1234_5678, memWrite=1, data_en=1:
  - states 3,5,6,1; address_out=0x100; data_out_BUS=0x12345678.
- Fetch with stall: instr_en=1, address_in=0x0, bus_full=1 for 3 cycles in Read_Request, then 0, data_in_BUS=0x0000_0013:
  - stays at state 2 for 3 cycles, then 4,6,1.
  - data_out_INSTR=0x13.
- Priority: instr_en=1, data_en=1, memRead=1, memWrite=1 simultaneously -> Write_Request taken first. The fetch completes after the following IDLE.
- Mid-transfer reset: assert rst while in Read -> state=INIT and outputs 0 next edge. No capture occurs.
